// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU controller: one quotient bit per cycle, using magnitudes plus sign fix-up.
// Outputs q/r/div_zero are stable between completions so HI/LO can read them at any time.
module div_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_mag, b_mag, rem, quo;
   logic             neg_a, neg_b;
   logic [CW-1:0]    cnt;
   logic             accept, zero_div;
   logic [WIDTH:0]   rem_sh;
   logic             ge;
   logic [WIDTH-1:0] rem_nx;

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      accept   = 1'b0;
      zero_div = (divisor == '0);
      case (state)
         IDLE, DONE: begin
            done     = (state == DONE);
            state_nx = IDLE;
            if (start) begin
               accept   = 1'b1;
               state_nx = zero_div ? DONE : PREP;
            end
         end
         PREP: begin
            busy     = 1'b1;
            state_nx = ITER;
         end
         ITER: begin
            busy = 1'b1;
            if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
         end
         FIX: begin
            busy     = 1'b1;
            state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
      if (flush) begin
         state_nx = IDLE;
         accept   = 1'b0;
      end
   end

   // The compare is WIDTH+1 bits wide; the subtraction result always fits in WIDTH bits.
   always_comb begin
      rem_sh = {rem, a_mag[WIDTH-1]};
      ge     = (rem_sh >= {1'b0, b_mag});
      rem_nx = ge ? (rem_sh[WIDTH-1:0] - b_mag) : rem_sh[WIDTH-1:0];
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         a_mag    <= '0;
         b_mag    <= '0;
         rem      <= '0;
         quo      <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         cnt      <= '0;
         q        <= '0;
         r        <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept && zero_div) begin
                  q        <= '1;
                  r        <= dividend;
                  div_zero <= 1'b1;
               end else if (accept) begin
                  a_mag <= dividend;
                  b_mag <= divisor;
                  neg_a <= is_signed & dividend[WIDTH-1];
                  neg_b <= is_signed & divisor[WIDTH-1];
               end
            end
            PREP: begin
               if (neg_a) a_mag <= -a_mag;
               if (neg_b) b_mag <= -b_mag;
               rem <= '0;
               quo <= '0;
               cnt <= '0;
            end
            ITER: begin
               a_mag <= {a_mag[WIDTH-2:0], 1'b0};
               rem   <= rem_nx;
               quo   <= {quo[WIDTH-2:0], ge};
               cnt   <= cnt + 1'b1;
            end
            FIX: begin
               // Sign flags already include is_signed, so unsigned ops pass straight through.
               if (!flush) begin
                  q        <= (neg_a ^ neg_b) ? -quo : quo;
                  r        <= neg_a ? -rem : rem;
                  div_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: expected results queued at issue, compared on each done pulse.
module tb_div_sequencer;

   logic        clock = 1'b0;
   logic        reset, start, is_signed, flush;
   logic [31:0] dividend, divisor;
   logic        busy, done, div_zero;
   logic [31:0] q, r;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } result_t;

   result_t sb[$];
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   div_sequencer #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
      .dividend(dividend), .divisor(divisor), .flush(flush),
      .busy(busy), .done(done), .q(q), .r(r), .div_zero(div_zero)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic result_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
      result_t res;
      longint sa, sb_;
      if (b == 0) begin
         res.q = '1; res.r = a; res.dz = 1'b1;
      end else if (s) begin
         sa = longint'(signed'(a));
         sb_ = longint'(signed'(b));
         res.q = 32'(sa / sb_); res.r = 32'(sa % sb_); res.dz = 1'b0;
      end else begin
         res.q = a / b; res.r = a % b; res.dz = 1'b0;
      end
      return res;
   endfunction

   always @(negedge clock) begin
      if (!reset && done) begin
         result_t e;
         done_cnt++;
         check("busy_in_done", 64'(busy), 64'd0);
         if (sb.size() == 0) check("spurious_done", 64'd1, 64'd0);
         else begin
            e = sb.pop_front();
            check("q", 64'(q), 64'(e.q));
            check("r", 64'(r), 64'(e.r));
            check("div_zero", 64'(div_zero), 64'(e.dz));
         end
      end
   end

   // Call at a negedge; drives start across one rising edge, then scrambles operands.
   task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b, input bit push);
      if (push) sb.push_back(model(s, a, b));
      is_signed = s; dividend = a; divisor = b; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
   endtask

   task automatic wait_done(output int lat, output int busy_cnt, input bit toggle);
      lat = 0; busy_cnt = 0;
      while (lat < 100) begin
         @(negedge clock);
         lat++;
         if (busy) busy_cnt++;
         if (done) break;
         if (toggle) begin
            dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
            start = (lat < 20) ? 1'($urandom) : 1'b0;
         end
      end
      start = 1'b0;
      if (!done) check("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b, input int exp_lat);
      int lat, bc;
      @(negedge clock);
      start_op(s, a, b, 1'b1);
      wait_done(lat, bc, 1'b0);
      if (exp_lat > 0) begin
         check("latency", 64'(lat), 64'(exp_lat));
         check("busy_cycles", 64'(bc), 64'(exp_lat - 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bc, dc;
      reset = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
      dividend = '0; divisor = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_q", 64'(q), 64'd0);
      check("rst_r", 64'(r), 64'd0);
      check("rst_dz", 64'(div_zero), 64'd0);
      reset = 1'b0;

      do_op(1'b0, 32'd100, 32'd7, 35);
      do_op(1'b1, -32'sd7, 32'd2, 35);
      do_op(1'b1, 32'd7, -32'sd2, 35);
      do_op(1'b1, -32'sd7, -32'sd2, 35);
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 35);
      do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 35);
      do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 35);
      do_op(1'b1, 32'd5, 32'd0, 1);
      do_op(1'b0, 32'd9, 32'd3, 35);
      for (int i = 0; i < 4; i++) do_op(1'($urandom), $urandom, 32'($urandom_range(1, 300)), 35);

      // flush mid-operation: results retained, no completion
      do_op(1'b0, 32'd100, 32'd7, 35);
      @(negedge clock);
      dc = done_cnt;
      start_op(1'b0, 32'd50, 32'd3, 1'b0);
      repeat (9) @(negedge clock);
      flush = 1'b1;
      @(posedge clock);
      #1 flush = 1'b0;
      @(negedge clock);
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_done", 64'(done), 64'd0);
      repeat (40) @(negedge clock);
      check("flush_q", 64'(q), 64'd14);
      check("flush_r", 64'(r), 64'd2);
      check("flush_no_done", 64'(done_cnt), 64'(dc));

      // reset mid-operation: outputs return to reset values
      @(negedge clock);
      start_op(1'b0, 32'd50, 32'd3, 1'b0);
      repeat (9) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst2_busy", 64'(busy), 64'd0);
      check("rst2_q", 64'(q), 64'd0);
      check("rst2_r", 64'(r), 64'd0);
      repeat (40) @(negedge clock);
      check("rst2_no_done", 64'(done_cnt), 64'(dc));

      // back-to-back issue during the DONE cycle
      @(negedge clock);
      start_op(1'b0, 32'd100, 32'd7, 1'b1);
      wait_done(lat, bc, 1'b0);
      start_op(1'b0, 32'd9, 32'd4, 1'b1);
      wait_done(lat, bc, 1'b0);
      check("b2b_latency", 64'(lat), 64'd35);

      // operands and start toggled while busy
      @(negedge clock);
      start_op(1'b1, -32'sd1000, 32'd33, 1'b1);
      wait_done(lat, bc, 1'b1);
      check("toggle_latency", 64'(lat), 64'd35);

      repeat (3) @(negedge clock);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
